// File: rtl/rv_ctrl_if.sv
// Handshake and control-bundle bus between IF/ID, the decode-control stage and EX.
// Master drives instructions, flush and EX backpressure; slave is the stage itself.
interface rv_ctrl_if #(
  parameter int ALU_OP_W = 2,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic                branch;
  logic                jump;
  logic                jalr;
  logic                mem_read;
  logic                mem_to_reg;
  logic                mem_write;
  logic                alu_src;
  logic                reg_write;
  logic                lui;
  logic                auipc;
  logic [ALU_OP_W-1:0] alu_op;
  logic [REG_AW-1:0]   rd;
  logic [REG_AW-1:0]   rs1;
  logic [REG_AW-1:0]   rs2;
  logic                illegal;
  logic                halted;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, branch, jump, jalr, mem_read, mem_to_reg,
           mem_write, alu_src, reg_write, lui, auipc, alu_op, rd, rs1, rs2,
           illegal, halted, stall_cnt
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, branch, jump, jalr, mem_read, mem_to_reg,
           mem_write, alu_src, reg_write, lui, auipc, alu_op, rd, rs1, rs2,
           illegal, halted, stall_cnt
  );
endinterface

// File: rtl/rv_ctrl_pipe.sv
// RV32I ID/EX decode-control stage: registered bundle, load-use interlock, RUN/HALT FSM, stall counter.
// Optional macro RV_CTRL_ILLEGAL_TRAP_EN: unknown opcodes raise illegal and halt instead of issuing a NOP.
module rv_ctrl_pipe #(
  parameter int ALU_OP_W = 2,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 16,
  parameter int LU_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  rv_ctrl_if.slave    bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t state_r, state_nx_s;

  logic                branch_s, jump_s, jalr_s, mem_read_s, mem_to_reg_s, mem_write_s;
  logic                alu_src_s, reg_write_s, lui_s, auipc_s, illegal_s, halt_req_s;
  logic                use_rd_s, use_rs1_s, use_rs2_s;
  logic [ALU_OP_W-1:0] alu_op_s;
  logic [REG_AW-1:0]   rd_s, rs1_s, rs2_s;
  logic                hazard_s, in_ready_s, accept_s, cnt_inc_s;

  logic                out_valid_r;
  logic                branch_r, jump_r, jalr_r, mem_read_r, mem_to_reg_r, mem_write_r;
  logic                alu_src_r, reg_write_r, lui_r, auipc_r, illegal_r;
  logic [ALU_OP_W-1:0] alu_op_r;
  logic [REG_AW-1:0]   rd_r, rs1_r, rs2_r;
  logic [CNT_W-1:0]    cnt_r;

  logic unused_instr_s;
  assign unused_instr_s = ^bus.instr;

  // Opcode decode into next-bundle controls and used register fields
  always_comb begin
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    jalr_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_to_reg_s = 1'b0;
    mem_write_s  = 1'b0;
    alu_src_s    = 1'b0;
    reg_write_s  = 1'b0;
    lui_s        = 1'b0;
    auipc_s      = 1'b0;
    illegal_s    = 1'b0;
    halt_req_s   = 1'b0;
    use_rd_s     = 1'b0;
    use_rs1_s    = 1'b0;
    use_rs2_s    = 1'b0;
    alu_op_s     = {ALU_OP_W{1'b0}};
    case (bus.instr[6:0])
      OP_R: begin
        reg_write_s = 1'b1; alu_op_s = ALU_OP_W'(2'b10);
        use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      OP_IALU: begin
        reg_write_s = 1'b1; alu_src_s = 1'b1; alu_op_s = ALU_OP_W'(2'b11);
        use_rd_s = 1'b1; use_rs1_s = 1'b1;
      end
      OP_LOAD: begin
        mem_read_s = 1'b1; mem_to_reg_s = 1'b1; reg_write_s = 1'b1; alu_src_s = 1'b1;
        use_rd_s = 1'b1; use_rs1_s = 1'b1;
      end
      OP_STORE: begin
        mem_write_s = 1'b1; alu_src_s = 1'b1;
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      OP_BR: begin
        branch_s = 1'b1; alu_op_s = ALU_OP_W'(2'b01);
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      OP_JAL: begin
        jump_s = 1'b1; reg_write_s = 1'b1; use_rd_s = 1'b1;
      end
      OP_JALR: begin
        jump_s = 1'b1; jalr_s = 1'b1; reg_write_s = 1'b1; alu_src_s = 1'b1;
        use_rd_s = 1'b1; use_rs1_s = 1'b1;
      end
      OP_LUI: begin
        lui_s = 1'b1; reg_write_s = 1'b1; alu_src_s = 1'b1; use_rd_s = 1'b1;
      end
      OP_AUIPC: begin
        auipc_s = 1'b1; reg_write_s = 1'b1; alu_src_s = 1'b1; use_rd_s = 1'b1;
      end
      OP_SYS: begin
        halt_req_s = 1'b1;
      end
      default: begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        illegal_s  = 1'b1;
        halt_req_s = 1'b1;
`else
        illegal_s  = 1'b0;
        halt_req_s = 1'b0;
`endif
      end
    endcase
    rd_s  = use_rd_s  ? bus.instr[7 +: REG_AW]  : {REG_AW{1'b0}};
    rs1_s = use_rs1_s ? bus.instr[15 +: REG_AW] : {REG_AW{1'b0}};
    rs2_s = use_rs2_s ? bus.instr[20 +: REG_AW] : {REG_AW{1'b0}};
  end

  // Unused rs fields are already zero, so a nonzero load rd can only match a real source
  always_comb begin
    hazard_s = (LU_STALL != 0) & out_valid_r & mem_read_r & (rd_r != {REG_AW{1'b0}}) &
               bus.in_valid & ((rd_r == rs1_s) | (rd_r == rs2_s));
    in_ready_s = ~rst & ~bus.flush & (state_r == ST_RUN) & ~hazard_s &
                 (~out_valid_r | bus.out_ready);
    accept_s   = bus.in_valid & in_ready_s;
    cnt_inc_s  = ~bus.flush & hazard_s & bus.out_ready & (cnt_r != {CNT_W{1'b1}});
  end

  // RUN/HALT next-state: flush always wins and returns to RUN
  always_comb begin
    state_nx_s = state_r;
    if (bus.flush) begin
      state_nx_s = ST_RUN;
    end else if (accept_s && halt_req_s) begin
      state_nx_s = ST_HALT;
    end else begin
      state_nx_s = state_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // ID/EX bundle register; flush only drops valid, fields keep their last values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      branch_r     <= 1'b0;
      jump_r       <= 1'b0;
      jalr_r       <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_to_reg_r <= 1'b0;
      mem_write_r  <= 1'b0;
      alu_src_r    <= 1'b0;
      reg_write_r  <= 1'b0;
      lui_r        <= 1'b0;
      auipc_r      <= 1'b0;
      illegal_r    <= 1'b0;
      alu_op_r     <= {ALU_OP_W{1'b0}};
      rd_r         <= {REG_AW{1'b0}};
      rs1_r        <= {REG_AW{1'b0}};
      rs2_r        <= {REG_AW{1'b0}};
    end else if (bus.flush) begin
      out_valid_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r  <= 1'b1;
      branch_r     <= branch_s;
      jump_r       <= jump_s;
      jalr_r       <= jalr_s;
      mem_read_r   <= mem_read_s;
      mem_to_reg_r <= mem_to_reg_s;
      mem_write_r  <= mem_write_s;
      alu_src_r    <= alu_src_s;
      reg_write_r  <= reg_write_s;
      lui_r        <= lui_s;
      auipc_r      <= auipc_s;
      illegal_r    <= illegal_s;
      alu_op_r     <= alu_op_s;
      rd_r         <= rd_s;
      rs1_r        <= rs1_s;
      rs2_r        <= rs2_s;
    end else if (bus.out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end

  // Saturating load-use bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.branch     = branch_r;
  assign bus.jump       = jump_r;
  assign bus.jalr       = jalr_r;
  assign bus.mem_read   = mem_read_r;
  assign bus.mem_to_reg = mem_to_reg_r;
  assign bus.mem_write  = mem_write_r;
  assign bus.alu_src    = alu_src_r;
  assign bus.reg_write  = reg_write_r;
  assign bus.lui        = lui_r;
  assign bus.auipc      = auipc_r;
  assign bus.alu_op     = alu_op_r;
  assign bus.rd         = rd_r;
  assign bus.rs1        = rs1_r;
  assign bus.rs2        = rs2_r;
  assign bus.illegal    = illegal_r;
  assign bus.halted     = (state_r == ST_HALT);
  assign bus.stall_cnt  = cnt_r;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// Scoreboard bench for rv_ctrl_pipe: driver pushes hand-computed bundles, monitor pops on each transfer.
// Uses a 2-bit stall counter so saturation is reachable.
module tb_rv_ctrl_pipe;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  typedef struct {
    bit          lat;
    int          acyc;
    logic [27:0] e;
  } exp_t;
  exp_t q[$];
  bit   ov_hist [0:1023];

  rv_ctrl_if #(.ALU_OP_W(2), .REG_AW(5), .CNT_W(CW)) bus ();

  rv_ctrl_pipe #(.ALU_OP_W(2), .REG_AW(5), .CNT_W(CW), .LU_STALL(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic [27:0] act;
  assign act = {bus.branch, bus.jump, bus.jalr, bus.mem_read, bus.mem_to_reg, bus.mem_write,
                bus.alu_src, bus.reg_write, bus.lui, bus.auipc, bus.alu_op,
                bus.rd, bus.rs1, bus.rs2, bus.illegal};

  function automatic logic [27:0] mk(input logic [9:0] c, input logic [1:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic ill);
    return {c, op, rd, rs1, rs2, ill};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
  endtask

  // control bits: {branch,jump,jalr,mr,m2r,mw,src,rw,lui,auipc}
  localparam logic [31:0] I_ADD312  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_LW54    = 32'h00022283;  // lw x5,0(x4)
  localparam logic [31:0] I_ADD651  = 32'h00128333;  // add x6,x5,x1
  localparam logic [31:0] I_LW04    = 32'h00022003;  // lw x0,0(x4)
  localparam logic [31:0] I_ADD601  = 32'h00100333;  // add x6,x0,x1
  localparam logic [31:0] I_ADDI715 = 32'h00508393;  // addi x7,x1,5
  localparam logic [31:0] I_ECALL   = 32'h00000073;
  localparam logic [31:0] I_ILL     = 32'h0000007F;

  logic [27:0] e_add312, e_lw54, e_add651, e_lw04, e_add601, e_addi, e_ecall, e_ill;
  initial begin
    e_add312 = mk(10'b0000000100, 2'b10, 5'd3, 5'd1, 5'd2, 1'b0);
    e_lw54   = mk(10'b0001101100, 2'b00, 5'd5, 5'd4, 5'd0, 1'b0);
    e_add651 = mk(10'b0000000100, 2'b10, 5'd6, 5'd5, 5'd1, 1'b0);
    e_lw04   = mk(10'b0001101100, 2'b00, 5'd0, 5'd4, 5'd0, 1'b0);
    e_add601 = mk(10'b0000000100, 2'b10, 5'd6, 5'd0, 5'd1, 1'b0);
    e_addi   = mk(10'b0000001100, 2'b11, 5'd7, 5'd1, 5'd0, 1'b0);
    e_ecall  = 28'h0000000;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    e_ill    = 28'h0000001;
`else
    e_ill    = 28'h0000000;
`endif
  end

  // Monitor: compare every transfer against the scoreboard head
  initial forever begin
    @(negedge clk);
    ov_hist[cyc % 1024] = bus.out_valid;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_bundle: got 0x%0h with empty scoreboard", act);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("bundle", {4'h0, act}, {4'h0, x.e});
        if (x.lat) chk("latency", cyc, x.acyc + 1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [27:0] e, input bit lat, output int acyc);
    bit got;
    got  = 1'b0;
    acyc = -1;
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got  = 1'b1;
        acyc = cyc;
        q.push_back('{lat: lat, acyc: cyc, e: e});
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!got) chk("accept_timeout", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, dummy;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_bundle", {4'h0, act}, 32'd0);
    #11 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_cnt", {30'd0, bus.stall_cnt}, 32'd0);
    @(posedge clk); #1;

    // back-to-back
    send(I_ADD312, e_add312, 1'b1, a0);
    send(I_LW54, e_lw54, 1'b1, a1);
    chk("b2b_gap", a1 - a0, 32'd1);
    idle(2);

    // load-use with bubble
    send(I_LW54, e_lw54, 1'b1, a0);
    send(I_ADD651, e_add651, 1'b1, a1);
    chk("lu_gap", a1 - a0, 32'd2);
    chk("lu_bubble", {31'd0, ov_hist[(a0 + 2) % 1024]}, 32'd0);
    chk("lu_cnt", {30'd0, bus.stall_cnt}, 32'd1);
    idle(2);

    // x0 destination: no interlock
    send(I_LW04, e_lw04, 1'b1, a0);
    send(I_ADD601, e_add601, 1'b1, a1);
    chk("x0_gap", a1 - a0, 32'd1);
    chk("x0_cnt", {30'd0, bus.stall_cnt}, 32'd1);
    idle(2);

    // counter saturation
    for (int i = 0; i < 4; i++) begin
      send(I_LW54, e_lw54, 1'b1, a0);
      send(I_ADD651, e_add651, 1'b1, a1);
      idle(1);
      if (i == 0) chk("sat_cnt_step", {30'd0, bus.stall_cnt}, 32'd2);
    end
    chk("sat_cnt_final", {30'd0, bus.stall_cnt}, 32'd3);
    idle(2);

    // backpressure hold
    bus.out_ready = 1'b0;
    send(I_ADDI715, e_addi, 1'b0, dummy);
    bus.in_valid = 1'b1;
    bus.instr    = I_ADD312;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold", {4'h0, act}, {4'h0, e_addi});
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(I_ADD312, e_add312, 1'b1, dummy);
    idle(2);

    // flush kills a held bundle and drops the concurrent input
    bus.out_ready = 1'b0;
    send(I_ADDI715, e_addi, 1'b0, dummy);
    bus.in_valid = 1'b1;
    bus.instr    = I_ADD312;
    bus.flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_kill_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_keep_rd", {27'd0, bus.rd}, 32'd7);
    q.delete();
    bus.out_ready = 1'b1;
    idle(1);

    // ecall halts, flush resumes
    send(I_ECALL, e_ecall, 1'b1, dummy);
    chk("halt_set", {31'd0, bus.halted}, 32'd1);
    bus.in_valid = 1'b1;
    bus.instr    = I_ADDI715;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("halt_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    chk("halt_flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("halt_cleared", {31'd0, bus.halted}, 32'd0);
    chk("halt_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_cnt_kept", {30'd0, bus.stall_cnt}, 32'd3);
    @(posedge clk); #1;

    // unknown opcode
    send(I_ILL, e_ill, 1'b1, dummy);
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    chk("ill_halted", {31'd0, bus.halted}, 32'd1);
    bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0;
`else
    chk("ill_halted", {31'd0, bus.halted}, 32'd0);
`endif
    idle(2);
    chk("scoreboard_drained", q.size(), 32'd0);

    // asynchronous reset mid-transfer
    bus.out_ready = 1'b0;
    send(I_ADDI715, e_addi, 1'b0, dummy);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_bundle", {4'h0, act}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("arst_cnt", {30'd0, bus.stall_cnt}, 32'd0);
    q.delete();
    #6 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("arst_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst_rel_halted", {31'd0, bus.halted}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
